// File: rtl/coin_return_sequencer.sv
// Change-return sequencer: runs the inactivity timeout, then pays out the
// balance one coin at a time over valid/ready, reporting each accepted coin.
module coin_return_sequencer #(
  parameter int kTotalBits = 31,
  parameter int kTimeout   = 10,
  parameter int kCoin0     = 100,
  parameter int kCoin1     = 500,
  parameter int kCoin2     = 1000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            i_input_coin,
  input  logic [3:0]            i_select_item,
  input  logic                  i_return_req,
  input  logic [kTotalBits-1:0] i_total,
  input  logic                  i_coin_ready,
  output logic                  o_coin_valid,
  output logic [2:0]            o_coin,
  output logic                  o_deduct_valid,
  output logic [kTotalBits-1:0] o_deduct_amount,
  output logic [31:0]           o_wait_time,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [kTotalBits-1:0] o_residual
);

  typedef enum logic [1:0] {IDLE, COUNT, RETURN, DONE} state_t;

  localparam logic [kTotalBits-1:0] C0 = kTotalBits'(kCoin0);
  localparam logic [kTotalBits-1:0] C1 = kTotalBits'(kCoin1);
  localparam logic [kTotalBits-1:0] C2 = kTotalBits'(kCoin2);

  state_t                state, state_nxt;
  logic [31:0]           wait_nxt;
  logic [kTotalBits-1:0] remaining, remaining_nxt, residual_nxt;
  logic [kTotalBits-1:0] coin_val;
  logic [2:0]            coin_sel;
  logic                  activity, fire;

  assign activity = (|i_input_coin) | (|i_select_item);

  // Greedy choice: largest coin not exceeding what is left to pay.
  always_comb begin
    coin_sel = '0;
    coin_val = '0;
    if (remaining >= C2) begin
      coin_sel = 3'b100;
      coin_val = C2;
    end else if (remaining >= C1) begin
      coin_sel = 3'b010;
      coin_val = C1;
    end else if (remaining >= C0) begin
      coin_sel = 3'b001;
      coin_val = C0;
    end
  end

  assign o_coin_valid = (state == RETURN) && (remaining >= C0);
  assign o_coin       = o_coin_valid ? coin_sel : '0;
  assign fire         = o_coin_valid & i_coin_ready;
  assign o_busy       = (state == RETURN) || (state == DONE);
  assign o_done       = (state == DONE);

  always_comb begin
    state_nxt     = state;
    wait_nxt      = o_wait_time;
    remaining_nxt = remaining;
    residual_nxt  = o_residual;
    unique case (state)
      IDLE: begin
        wait_nxt = '0;
        if (i_return_req) begin
          state_nxt     = RETURN;
          remaining_nxt = i_total;
          residual_nxt  = '0;
        end else if (activity) begin
          state_nxt = COUNT;
          wait_nxt  = 32'(kTimeout);
        end
      end
      COUNT: begin
        if (i_return_req || (!activity && o_wait_time == 32'd1)) begin
          state_nxt     = RETURN;
          wait_nxt      = '0;
          remaining_nxt = i_total;
          residual_nxt  = '0;
        end else if (activity) begin
          wait_nxt = 32'(kTimeout);
        end else begin
          wait_nxt = o_wait_time - 32'd1;
        end
      end
      RETURN: begin
        if (!o_coin_valid) begin
          state_nxt    = DONE;
          residual_nxt = remaining;
        end else if (fire) begin
          remaining_nxt = remaining - coin_val;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      o_wait_time     <= '0;
      remaining       <= '0;
      o_residual      <= '0;
      o_deduct_valid  <= 1'b0;
      o_deduct_amount <= '0;
    end else begin
      state          <= state_nxt;
      o_wait_time    <= wait_nxt;
      remaining      <= remaining_nxt;
      o_residual     <= residual_nxt;
      o_deduct_valid <= fire;
      if (fire) o_deduct_amount <= coin_val;
    end
  end

endmodule
